// File: rtl/sd101_mealy.sv
// sd101_mealy: Mealy "101" serial detector with exported present/next state.
// Optional saturating match counter (det_count) is built when SD101_COUNT_EN is defined.
module sd101_mealy #(
    parameter int OVERLAP = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    output logic               dout,
    output logic [1:0]         PS_out,
    output logic [1:0]         NS_out
`ifdef SD101_COUNT_EN
    ,
    output logic [COUNT_W-1:0] det_count
`endif
);

    // state | meaning
    // S0    | idle, no partial match
    // S1    | seen "1"
    // S2    | seen "10"
    // S_ILL | unreachable encoding, recovers to S0 with dout low
    typedef enum logic [1:0] {
        S0    = 2'b00,
        S1    = 2'b01,
        S2    = 2'b10,
        S_ILL = 2'b11
    } state_t;

    state_t r_ps;
    state_t w_ns;

    if (COUNT_W < 1) begin : g_bad_count_w
        $error("sd101_mealy: COUNT_W must be at least 1");
    end

    always_comb begin
        w_ns = S0;
        case (r_ps)
            S0:      w_ns = din ? S1 : S0;
            S1:      w_ns = din ? S1 : S2;
            S2:      w_ns = (din && (OVERLAP != 0)) ? S1 : S0;
            default: w_ns = S0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps <= S0;
        end else begin
            r_ps <= w_ns;
        end
    end

    assign dout   = (r_ps == S2) & din;
    assign PS_out = r_ps;
    assign NS_out = w_ns;

`ifdef SD101_COUNT_EN
    logic [COUNT_W-1:0] r_det_count;

    // Saturates rather than wraps so a long-running count never reads as few matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_count <= '0;
        end else if (dout && (r_det_count != {COUNT_W{1'b1}})) begin
            r_det_count <= r_det_count + COUNT_W'(1);
        end
    end

    assign det_count = r_det_count;
`endif

endmodule

// File: tb/tb_sd101_mealy.sv
// tb_sd101_mealy: directed-vector bench for sd101_mealy, overlapping and
// non-overlapping instances side by side; checks det_count when SD101_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_sd101_mealy;

    logic       clk;
    logic       rst;
    logic       din;
    logic       dout_ov;
    logic       dout_no;
    logic [1:0] ps_ov;
    logic [1:0] ns_ov;
    logic [1:0] ps_no;
    logic [1:0] ns_no;
`ifdef SD101_COUNT_EN
    logic [7:0] cnt_ov;
    logic [1:0] cnt_no;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sd101_mealy #(.OVERLAP(1), .COUNT_W(8)) u_ov (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout_ov),
        .PS_out    (ps_ov),
        .NS_out    (ns_ov)
`ifdef SD101_COUNT_EN
        ,
        .det_count (cnt_ov)
`endif
    );

    sd101_mealy #(.OVERLAP(0), .COUNT_W(2)) u_no (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout_no),
        .PS_out    (ps_no),
        .NS_out    (ns_no)
`ifdef SD101_COUNT_EN
        ,
        .det_count (cnt_no)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive bit, check Mealy outputs, clock it, check state.
    task automatic apply(input string tag, input logic d,
                         input logic [1:0] exp_ps_ov, input logic [1:0] exp_ps_no,
                         input logic exp_do_ov, input logic exp_do_no);
        din = d;
        #1;
        chk({tag, " dout_ov"}, 32'(dout_ov), 32'(exp_do_ov));
        chk({tag, " dout_no"}, 32'(dout_no), 32'(exp_do_no));
        chk({tag, " ns_ov"},   32'(ns_ov),   32'(exp_ps_ov));
        chk({tag, " ns_no"},   32'(ns_no),   32'(exp_ps_no));
        @(posedge clk);
        #1;
        chk({tag, " ps_ov"},   32'(ps_ov),   32'(exp_ps_ov));
        chk({tag, " ps_no"},   32'(ps_no),   32'(exp_ps_no));
        @(negedge clk);
    endtask

    // Overlap stream 1,0,1,0,1,0,0 with expected states/outputs for both instances.
    logic       ov_din   [7] = '{1, 0, 1, 0, 1, 0, 0};
    logic [1:0] ov_ps_ov [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [1:0] ov_ps_no [7] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic       ov_do_ov [7] = '{0, 0, 1, 0, 1, 0, 0};
    logic       ov_do_no [7] = '{0, 0, 1, 0, 0, 0, 0};

    // Runs 1,1,1,0,0,1 then 1,0,1 starting from S0 on both instances.
    logic       rn_din   [9] = '{1, 1, 1, 0, 0, 1, 1, 0, 1};
    logic [1:0] rn_ps_ov [9] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] rn_ps_no [9] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic       rn_do    [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst = 1'b1;
        din = 1'b0;
        #10;
        chk("rst ps_ov",   32'(ps_ov),   32'd0);
        chk("rst ns_ov",   32'(ns_ov),   32'd0);
        chk("rst dout_ov", 32'(dout_ov), 32'd0);
        chk("rst ps_no",   32'(ps_no),   32'd0);
        din = 1'b1;
        #1;
        chk("rst din1 ns_ov",   32'(ns_ov),   32'd1);
        chk("rst din1 ps_ov",   32'(ps_ov),   32'd0);
        chk("rst din1 dout_ov", 32'(dout_ov), 32'd0);
        @(posedge clk);
        #1;
        chk("rst edge ps_ov", 32'(ps_ov), 32'd0);
        chk("rst edge ps_no", 32'(ps_no), 32'd0);
`ifdef SD101_COUNT_EN
        chk("rst cnt_ov", 32'(cnt_ov), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            apply($sformatf("ovl[%0d]", i), ov_din[i], ov_ps_ov[i], ov_ps_no[i], ov_do_ov[i], ov_do_no[i]);
`ifdef SD101_COUNT_EN
        chk("ovl cnt_ov", 32'(cnt_ov), 32'd2);
        chk("ovl cnt_no", 32'(cnt_no), 32'd1);
`endif

        apply("toS2 a", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
        apply("toS2 b", 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        din = 1'b1;
        #1;
        chk("mealy hi1 dout_ov", 32'(dout_ov), 32'd1);
        chk("mealy hi1 dout_no", 32'(dout_no), 32'd1);
        din = 1'b0;
        #1;
        chk("mealy lo dout_ov", 32'(dout_ov), 32'd0);
        din = 1'b1;
        #1;
        chk("mealy hi2 dout_ov", 32'(dout_ov), 32'd1);
        chk("mealy hi2 ns_no",   32'(ns_no),   32'd0);
        rst = 1'b1;
        #1;
        chk("async ps_ov",   32'(ps_ov),   32'd0);
        chk("async ps_no",   32'(ps_no),   32'd0);
        chk("async dout_ov", 32'(dout_ov), 32'd0);
        chk("async ns_ov",   32'(ns_ov),   32'd1);
`ifdef SD101_COUNT_EN
        chk("async cnt_ov", 32'(cnt_ov), 32'd0);
        chk("async cnt_no", 32'(cnt_no), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        apply("post 0", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        apply("post 1", 1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
        apply("post 0b", 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
        apply("post 1b", 1'b1, 2'b01, 2'b00, 1'b1, 1'b1);
        apply("idle a", 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
        apply("idle b", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++)
            apply($sformatf("run[%0d]", i), rn_din[i], rn_ps_ov[i], rn_ps_no[i], rn_do[i], rn_do[i]);
`ifdef SD101_COUNT_EN
        chk("run cnt_ov", 32'(cnt_ov), 32'd2);
        chk("run cnt_no", 32'(cnt_no), 32'd2);
        // Four more "101" patterns: overlapping instance counts to 6, 2-bit counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("sat[%0d] a", i), 1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
            apply($sformatf("sat[%0d] b", i), 1'b0, 2'b10, 2'b10, 1'b0, 1'b0);
            apply($sformatf("sat[%0d] c", i), 1'b1, 2'b01, 2'b00, 1'b1, 1'b1);
        end
        chk("sat cnt_ov", 32'(cnt_ov), 32'd6);
        chk("sat cnt_no", 32'(cnt_no), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
